// File: rtl/nabp_filtered_line_loader.sv
// Requester side of the angle handshake: sweeps one projection line per angle
// into a two-bank line buffer, one bank filling while the other is read.
//   state     | meaning
//   ready_s   | idle, waiting for hs_kick
//   request_s | fr_next_angle high, waiting for ack or end of angles
//   fill_s    | sweeping fr_s_val and writing delayed sg_data to the write bank
//   swap_s    | write bank full, waiting for the read bank to be released
//   finish_s  | no more angles, waiting for the last line to be released
module nabp_filtered_line_loader #(
  parameter int kSLength       = 9,
  parameter int kAngleLength   = 9,
  parameter int kDataLength    = 16,
  parameter int kLineSize      = 256,
  parameter int kSgReadLatency = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    hs_kick,
  output logic                    hs_done,
  input  logic [kAngleLength-1:0] fr_angle,
  input  logic                    fr_has_next_angle,
  input  logic                    fr_next_angle_ack,
  output logic                    fr_next_angle,
  output logic [kSLength-1:0]     fr_s_val,
  input  logic [kDataLength-1:0]  sg_data,
  output logic                    pr_line_valid,
  output logic [kAngleLength-1:0] pr_angle,
  input  logic [kSLength-1:0]     pr_rd_addr,
  output logic [kDataLength-1:0]  pr_rd_data,
  input  logic                    pr_next_angle
);

  localparam int kAddrW = (kLineSize > 1) ? $clog2(kLineSize) : 1;
  localparam int kLat   = kSgReadLatency;

  typedef enum logic [2:0] {
    ready_s,
    request_s,
    fill_s,
    swap_s,
    finish_s
  } state_t;

  state_t                  state, state_nxt;
  logic                    bank_sel;
  logic                    wr_full;
  logic                    sweep_done;
  logic [kAngleLength-1:0] wr_angle;
  logic [kLat-1:0]         pipe_valid;
  logic [kAddrW-1:0]       pipe_addr [kLat];
  logic [kDataLength-1:0]  mem [2][2**kAddrW];
  logic                    rd_free;
  logic                    fill_done;
  logic                    swap_go;
  logic                    issue;
  logic                    rd_in_range;

  always_comb begin
    rd_free       = !pr_line_valid || pr_next_angle;
    fill_done     = pipe_valid[kLat-1] && (pipe_addr[kLat-1] == kAddrW'(kLineSize - 1));
    swap_go       = (state == swap_s) && wr_full && rd_free;
    issue         = (state == fill_s) && !sweep_done;
    state_nxt     = state;
    fr_next_angle = 1'b0;
    hs_done       = 1'b0;
    case (state)
      ready_s: begin
        if (hs_kick) state_nxt = request_s;
      end
      request_s: begin
        fr_next_angle = 1'b1;
        if (fr_next_angle_ack)      state_nxt = fill_s;
        else if (!fr_has_next_angle) state_nxt = finish_s;
      end
      fill_s: begin
        if (fill_done) state_nxt = swap_s;
      end
      swap_s: begin
        if (swap_go) state_nxt = request_s;
      end
      finish_s: begin
        if (rd_free) begin
          hs_done   = 1'b1;
          state_nxt = ready_s;
        end
      end
      default: state_nxt = ready_s;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= ready_s;
      fr_s_val      <= '0;
      sweep_done    <= 1'b0;
      wr_angle      <= '0;
      wr_full       <= 1'b0;
      bank_sel      <= 1'b0;
      pipe_valid    <= '0;
      pr_line_valid <= 1'b0;
      pr_angle      <= '0;
      for (int i = 0; i < kLat; i++) pipe_addr[i] <= '0;
    end else begin
      state <= state_nxt;

      if (state == request_s) begin
        fr_s_val   <= '0;
        sweep_done <= 1'b0;
      end else if (issue) begin
        if (fr_s_val == kSLength'(kLineSize - 1)) sweep_done <= 1'b1;
        else                                       fr_s_val   <= fr_s_val + 1'b1;
      end

      // fr_angle moved on the ack edge, so the first fill cycle sees the new angle
      if (issue && (fr_s_val == '0)) wr_angle <= fr_angle;

      pipe_valid[0] <= issue;
      pipe_addr[0]  <= fr_s_val[kAddrW-1:0];
      for (int i = 1; i < kLat; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_addr[i]  <= pipe_addr[i-1];
      end

      if (fill_done)    wr_full <= 1'b1;
      else if (swap_go) wr_full <= 1'b0;

      if (swap_go) begin
        bank_sel      <= ~bank_sel;
        pr_line_valid <= 1'b1;
        pr_angle      <= wr_angle;
      end else if (pr_next_angle) begin
        pr_line_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && pipe_valid[kLat-1]) mem[~bank_sel][pipe_addr[kLat-1]] <= sg_data;
  end

  assign rd_in_range = ({1'b0, pr_rd_addr} < (kSLength + 1)'(kLineSize));

  always_ff @(posedge clk) begin
    if (!reset_n)         pr_rd_data <= '0;
    else if (rd_in_range) pr_rd_data <= mem[bank_sel][pr_rd_addr[kAddrW-1:0]];
    else                  pr_rd_data <= '0;
  end

endmodule
